// File: rtl/clint_pkg.sv
// Shared types and width helpers for the CLINT RTC tick generator.
package clint_pkg;

  localparam int unsigned MODE_W          = 2;
  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned SYNC_STAGES_MAX = 4;

  typedef enum logic [MODE_W-1:0] {
    DETECT   = 2'b00,
    EXTERNAL = 2'b01,
    INTERNAL = 2'b10
  } rtc_mode_e;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int unsigned width_of(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clint_rtc_tick_gen_if.sv
// RTC pin in, CLINT increment pulse and source status out.
interface clint_rtc_tick_gen_if;
  import clint_pkg::*;

  logic              rtc_i;
  logic              tick_o;
  logic [MODE_W-1:0] mode_o;
  logic              rtc_lost_o;

  modport master (output rtc_i, input tick_o, mode_o, rtc_lost_o);
  modport slave  (input rtc_i, output tick_o, mode_o, rtc_lost_o);
endinterface

// File: rtl/clint_rtc_sync.sv
// Async pin synchroniser with registered rising-edge detect. Defining
// CLINT_RTC_GLITCH_FILTER_EN inserts a FILTER_LEN-cycle stable-level filter.
module clint_rtc_sync
  import clint_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic serial_i,
  output logic r_edge_o,
  output logic level_o
);

   if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX || FILTER_LEN < 1)
   begin : g_param_check
      $error("clint_rtc_sync: SYNC_STAGES must be 2..4 and FILTER_LEN >= 1");
   end

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   level;
   logic                   hist_q;
   logic                   edge_q;

   // NOTE: flops are written with <= so each one samples the pre-edge value of
   // its neighbour; blocking here would collapse the chain into a single stage.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sync_q <= '0;
      else          sync_q <= {sync_q[SYNC_STAGES-2:0], serial_i};
   end

`ifdef CLINT_RTC_GLITCH_FILTER_EN
   localparam int unsigned FCNT_W = width_of(FILTER_LEN);
   localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILTER_LEN - 1);

   logic [FCNT_W-1:0] fcnt_q;
   logic              filt_q;

   // Filtered level follows only after FILTER_LEN consecutive disagreeing samples.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fcnt_q <= '0;
         filt_q <= 1'b0;
      end else if (sync_q[SYNC_STAGES-1] == filt_q) begin
         fcnt_q <= '0;
      end else if (fcnt_q == FCNT_LAST) begin
         fcnt_q <= '0;
         filt_q <= sync_q[SYNC_STAGES-1];
      end else begin
         fcnt_q <= fcnt_q + 1'b1;
      end
   end

   assign level = filt_q;
`else
   assign level = sync_q[SYNC_STAGES-1];
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hist_q <= 1'b0;
         edge_q <= 1'b0;
      end else begin
         hist_q <= level;
         edge_q <= level & ~hist_q;
      end
   end

   assign r_edge_o = edge_q;
   assign level_o  = level;

endmodule

// File: rtl/clint_rtc_tick_gen.sv
// CLINT timer-increment source: locks to the RTC pin, falls back to an internal
// prescaler when it stalls. CLINT_RTC_GLITCH_FILTER_EN enables the pin filter.
module clint_rtc_tick_gen
  import clint_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 4096,
  parameter int unsigned LOCK_EDGES  = 2,
  parameter int unsigned INT_DIV     = 1024,
  parameter int unsigned FILTER_LEN  = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  clint_rtc_tick_gen_if.slave  bus
);

   if (TIMEOUT < 2 || LOCK_EDGES < 1 || INT_DIV < 2) begin : g_param_check
      $error("clint_rtc_tick_gen: need TIMEOUT >= 2, LOCK_EDGES >= 1, INT_DIV >= 2");
   end

   localparam int unsigned WD_W = width_of(TIMEOUT + 1);
   localparam int unsigned LK_W = width_of(LOCK_EDGES + 1);
   localparam int unsigned PC_W = width_of(INT_DIV);

   localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
   localparam logic [LK_W-1:0] LK_LOCK = LK_W'(LOCK_EDGES - 1);
   localparam logic [PC_W-1:0] PC_LAST = PC_W'(INT_DIV - 1);

   logic            rtc_edge;
   logic            rtc_level_unused;
   logic            timeout;
   logic            tick;
   logic [WD_W-1:0] wd_q;
   logic [LK_W-1:0] lk_q, lk_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            lost_q, lost_d;
   rtc_mode_e       state_q, state_d;

   clint_rtc_sync #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
   ) u_sync (
      .clk      (clk),
      .reset_n  (reset_n),
      .serial_i (bus.rtc_i),
      .r_edge_o (rtc_edge),
      .level_o  (rtc_level_unused)
   );

   // Watchdog saturates so a dead RTC raises timeout exactly once.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)              wd_q <= '0;
      else if (rtc_edge)         wd_q <= '0;
      else if (wd_q != WD_MAX)   wd_q <= wd_q + 1'b1;
   end

   assign timeout = (wd_q == WD_LAST) && !rtc_edge;

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves
      // one unassigned, which would otherwise infer a latch.
      state_d = state_q;
      lk_d    = lk_q;
      pc_d    = pc_q;
      lost_d  = lost_q;
      tick    = 1'b0;
      case (state_q)
         DETECT: begin
            if (rtc_edge) begin
               if (lk_q >= LK_LOCK) begin
                  state_d = EXTERNAL;
                  lk_d    = '0;
               end else begin
                  lk_d = lk_q + 1'b1;
               end
            end else if (timeout) begin
               state_d = INTERNAL;
               lk_d    = '0;
               pc_d    = '0;
            end
         end
         EXTERNAL: begin
            tick = rtc_edge;
            if (timeout) begin
               state_d = INTERNAL;
               lost_d  = 1'b1;
               pc_d    = '0;
            end
         end
         INTERNAL: begin
            // A returning RTC edge preempts the prescaler tick and counts toward lock.
            if (rtc_edge) begin
               state_d = DETECT;
               pc_d    = '0;
               lk_d    = LK_W'(1);
            end else begin
               tick = (pc_q == PC_LAST);
               pc_d = tick ? '0 : pc_q + 1'b1;
            end
         end
         default: begin
            state_d = DETECT;
            lk_d    = '0;
            pc_d    = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= DETECT;
         lk_q    <= '0;
         pc_q    <= '0;
         lost_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         lk_q    <= lk_d;
         pc_q    <= pc_d;
         lost_q  <= lost_d;
      end
   end

   assign bus.tick_o     = tick;
   assign bus.mode_o     = (state_q == EXTERNAL || state_q == INTERNAL) ? state_q : DETECT;
   assign bus.rtc_lost_o = lost_q;

endmodule

// File: tb/tb_clint_rtc_tick_gen.sv
// Self-checking bench for clint_rtc_tick_gen: mode/lost checkpoint tables plus
// a tick-time scoreboard. Build with CLINT_RTC_GLITCH_FILTER_EN for filter cases.
module tb_clint_rtc_tick_gen;
   import clint_pkg::*;

   localparam int unsigned SYNC_STAGES = 2;
   localparam int unsigned TIMEOUT     = 16;
   localparam int unsigned LOCK_EDGES  = 2;
   localparam int unsigned INT_DIV     = 4;
   localparam int unsigned FILTER_LEN  = 3;
`ifdef CLINT_RTC_GLITCH_FILTER_EN
   localparam int LAT = SYNC_STAGES + FILTER_LEN + 1;
`else
   localparam int LAT = SYNC_STAGES + 1;
`endif
   localparam int NP = -1000;   // "no pulse" marker

   // Inputs: extra rtc pulse window, cycle to run to. Outputs: mode, lost.
   typedef struct {
      string      name;
      int         pulse_lo;
      int         pulse_hi;
      int         cyc;
      logic [1:0] mode;
      logic       lost;
   } vec_t;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   clint_rtc_tick_gen_if bus ();

   clint_rtc_tick_gen #(
      .SYNC_STAGES (SYNC_STAGES),
      .TIMEOUT     (TIMEOUT),
      .LOCK_EDGES  (LOCK_EDGES),
      .INT_DIV     (INT_DIV),
      .FILTER_LEN  (FILTER_LEN)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   int   pulse_lo = NP;
   int   pulse_hi = NP;
   int   edges_q[$];       // cycles at which the synchronised edge should appear
   int   exp_tick_q[$];    // scoreboard of expected tick_o cycles
   logic prev_tick = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // rtc_i is high for 4 cycles starting LAT cycles before each planned edge.
   function automatic logic rtc_at(input int c);
      logic v;
      v = 1'b0;
      foreach (edges_q[i])
         if (c >= edges_q[i] - LAT && c <= edges_q[i] - LAT + 3) v = 1'b1;
      if (c >= pulse_lo && c <= pulse_hi) v = 1'b1;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      bus.rtc_i = rtc_at(cyc);
      while (exp_tick_q.size() > 0 && exp_tick_q[0] < cyc) begin
         check($sformatf("tick_missing_at_%0d", exp_tick_q[0]), 32'd0, 32'd1);
         void'(exp_tick_q.pop_front());
      end
      if (bus.tick_o) begin
         check("tick_cycle", cyc, (exp_tick_q.size() > 0) ? exp_tick_q[0] : -1);
         if (exp_tick_q.size() > 0 && exp_tick_q[0] == cyc) void'(exp_tick_q.pop_front());
         check("tick_back_to_back", prev_tick, 1'b0);
      end
      prev_tick = bus.tick_o;
   endtask

   task automatic run_vec(input vec_t v);
      pulse_lo = v.pulse_lo;
      pulse_hi = v.pulse_hi;
      while (cyc < v.cyc) step();
      check($sformatf("%s.mode", v.name), bus.mode_o, v.mode);
      check($sformatf("%s.lost", v.name), bus.rtc_lost_o, v.lost);
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      bus.rtc_i = 1'b0;
      edges_q.delete();
      exp_tick_q.delete();
      pulse_lo = NP;
      pulse_hi = NP;
      repeat (3) @(posedge clk);
      #1;
      reset_n   = 1'b1;
      cyc       = 0;
      prev_tick = 1'b0;
   endtask

   vec_t seg1[10];
   vec_t seg2[3];
`ifdef CLINT_RTC_GLITCH_FILTER_EN
   vec_t seg3[4];
`endif

   initial begin
      seg1 = '{
         '{"detect_first_edge",  NP, NP,   8, 2'b00, 1'b0},
         '{"detect_second_edge", NP, NP,  16, 2'b00, 1'b0},
         '{"locked",             NP, NP,  17, 2'b01, 1'b0},
         '{"ext_last_cycle",     NP, NP,  56, 2'b01, 1'b0},
         '{"rtc_lost",           NP, NP,  57, 2'b10, 1'b1},
         '{"int_edge_cycle",     NP, NP,  80, 2'b10, 1'b1},
         '{"redetect",           NP, NP,  81, 2'b00, 1'b1},
         '{"redetect_hold",      NP, NP,  88, 2'b00, 1'b1},
         '{"relock",             NP, NP,  89, 2'b01, 1'b1},
         '{"ext_again",          NP, NP, 104, 2'b01, 1'b1}
      };
      seg2 = '{
         '{"no_rtc_detect",      NP, NP,  15, 2'b00, 1'b0},
         '{"no_rtc_internal",    NP, NP,  16, 2'b10, 1'b0},
         '{"no_rtc_no_lost",     NP, NP,  32, 2'b10, 1'b0}
      };
`ifdef CLINT_RTC_GLITCH_FILTER_EN
      seg3 = '{
         '{"glitch_ignored",     33, 34,  45, 2'b10, 1'b0},
         '{"long_pulse_pre",     46, 55,  52, 2'b10, 1'b0},
         '{"long_pulse_edge",    46, 55,  53, 2'b00, 1'b0},
         '{"long_pulse_after",   46, 55,  60, 2'b00, 1'b0}
      };
`endif

      // Reset state with no clock edge seen yet.
      reset_n   = 1'b1;
      bus.rtc_i = 1'b0;
      #1 reset_n = 1'b0;
      #1;
      check("reset.tick", bus.tick_o, 1'b0);
      check("reset.mode", bus.mode_o, 2'b00);
      check("reset.lost", bus.rtc_lost_o, 1'b0);

      // Lock, RTC stalls, fallback, RTC resumes and relocks.
      apply_reset();
      edges_q    = '{8, 16, 24, 32, 40, 80, 88, 96, 104};
      exp_tick_q = '{24, 32, 40, 60, 64, 68, 72, 76, 96, 104};
      for (int i = 0; i < $size(seg1); i++) run_vec(seg1[i]);
      check("seg1.pending_ticks", exp_tick_q.size(), 0);

      // Asynchronous reset while tick_o is high.
      check("pre_reset.tick", bus.tick_o, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      check("async_reset.tick", bus.tick_o, 1'b0);
      check("async_reset.mode", bus.mode_o, 2'b00);
      check("async_reset.lost", bus.rtc_lost_o, 1'b0);

      // RTC absent from reset: internal prescaler only, no lost flag.
      apply_reset();
`ifdef CLINT_RTC_GLITCH_FILTER_EN
      exp_tick_q = '{19, 23, 27, 31, 35, 39, 43, 47, 51};
`else
      exp_tick_q = '{19, 23, 27, 31};
`endif
      for (int i = 0; i < $size(seg2); i++) run_vec(seg2[i]);
`ifdef CLINT_RTC_GLITCH_FILTER_EN
      for (int i = 0; i < $size(seg3); i++) run_vec(seg3[i]);
`endif
      check("seg2.pending_ticks", exp_tick_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/clint_rtc_tick_gen.md
Name: clint_rtc_tick_gen

Overview:
- Upstream feeder of the CLINT's timer-increment input.
- Synchronises the asynchronous RTC pin (nominally 32.768 kHz) into the core clock domain and detects its rising edges.
- Emits a single-cycle increment pulse per RTC period.
- Falls back to an internal clk prescaler when the RTC is absent or stalls, so mtime always advances at a bounded rate.

Parameters:
- SYNC_STAGES, 2, synchroniser flop count (legal values 2..4).
- TIMEOUT, 4096, clk cycles without an RTC edge before the RTC is declared dead.
- LOCK_EDGES, 2, consecutive in-time RTC edges required to lock onto the external RTC.
- INT_DIV, 1024, internal prescaler divide ratio when in fallback (>=2).
- FILTER_LEN, 3, stable-level cycles required by the optional glitch filter.

Ports:
- clk, input, 1, core clock.
- reset_n, input, 1, asynchronous active-low reset.
- rtc_i, input, 1, raw asynchronous RTC input.
- tick_o, output, 1, one-cycle increment pulse to the CLINT.
- mode_o, output, 2, current source: 00 DETECT, 01 EXTERNAL, 10 INTERNAL.
- rtc_lost_o, output, 1, sticky flag set on EXTERNAL->INTERNAL; cleared only by reset.

Behaviour:
- Reset is asynchronous, active-low (reset_n); all flops clear on assertion.
  - Synchroniser chain 0, level history 0, counters 0, state DETECT.
  - tick_o=0, mode_o=00, rtc_lost_o=0.
- Synchroniser: SYNC_STAGES flops on rtc_i, plus one history flop.
  - edge = sync & ~hist.
  - Latency from an rtc_i rise to the edge pulse is SYNC_STAGES+1 clk cycles.
- Watchdog counter wd, width $clog2(TIMEOUT+1):
  - Cleared on every edge; otherwise increments.
  - Saturates at TIMEOUT.
  - timeout = (wd == TIMEOUT-1) && !edge.
- Lock counter lk, width $clog2(LOCK_EDGES+1).
- DETECT state:
  - tick_o held at 0.
  - edge: lk++. When lk reaches LOCK_EDGES -> EXTERNAL, lk cleared.
  - timeout: -> INTERNAL, lk cleared, prescaler cleared.
  - The first edge after reset counts toward lock (wd starts at 0).
- EXTERNAL state:
  - tick_o = edge, combinational from the registered edge, one cycle wide.
  - timeout: -> INTERNAL, rtc_lost_o <= 1, no tick in the transition cycle.
- INTERNAL state:
  - Prescaler pc, width $clog2(INT_DIV), counts 0..INT_DIV-1 and wraps to 0.
  - tick_o=1 when pc==INT_DIV-1.
  - edge: -> DETECT, pc cleared, lk=1 (this edge counts). No tick in that cycle, even if pc==INT_DIV-1.
- Simultaneous events:
  - edge and wd==TIMEOUT-1 in the same cycle: edge wins, timeout is not taken.
  - In DETECT, edge arriving on the cycle lk would time out: lock progress wins.
- Rate bound: tick_o is never asserted on two consecutive cycles.
  - Guaranteed in EXTERNAL because the edge needs a low sync level in between.
  - Guaranteed in INTERNAL by INT_DIV>=2.
- Reset mid-operation: immediate return to DETECT. No tick is produced during reset or in the first cycle after release.
- Illegal state encoding (11): recovers to DETECT on the next clk, outputs as in DETECT.

Optional Feature:
- Macro: CLINT_RTC_GLITCH_FILTER_EN.
- Defined:
  - A filter stage sits between the synchroniser and the history flop.
  - The filtered level changes only after the synchronised level has differed from it for FILTER_LEN consecutive cycles.
  - Pulses shorter than FILTER_LEN cycles are ignored.
  - Edge latency becomes SYNC_STAGES+FILTER_LEN+1.
- Undefined: the filter is absent; the history flop is fed directly from the synchroniser.

Decomposition:
- Package clint_pkg:
  - Mode enum rtc_mode_e (DETECT=2'b00, EXTERNAL=2'b01, INTERNAL=2'b10).
  - Width helper constants.
- Sub-module clint_rtc_sync:
  - Synchroniser, optional filter and edge detector.
  - Ports clk, reset_n, serial_i, r_edge_o, level_o.
  - Reused elsewhere for other async pins.
- Top module: FSM, watchdog, lock counter, prescaler.

Test Plan (TIMEOUT=16, LOCK_EDGES=2, INT_DIV=4, SYNC_STAGES=2 unless noted):
1. Reset then rtc_i toggling with period 8 clk -> mode 00 until the 2nd synchronised edge, then 01. One tick_o per rtc rise, each 3 cycles after the rise; no tick in DETECT.
2. rtc_i held at 0 from reset -> mode 10 after 16 cycles. tick_o every 4th cycle thereafter; rtc_lost_o stays 0.
3. Locked (scenario 1), then rtc_i stops -> 16 cycles after the last edge mode becomes 10 and rtc_lost_o rises to 1. The first internal tick follows 4 cycles later.
4. In INTERNAL, rtc_i resumes with period 8 -> mode 00 on the first edge with no tick that cycle. Mode 01 on the next edge; rtc_lost_o remains 1.
5. reset_n asserted asynchronously mid-tick -> tick_o, mode_o and rtc_lost_o go to 0 immediately without waiting for a clk edge.
6. With CLINT_RTC_GLITCH_FILTER_EN and FILTER_LEN=3: a 2-cycle rtc_i high pulse produces no edge. A 10-cycle high pulse produces one edge 6 cycles after the rise.
